// File: rtl/spi_reg_controller_pkg.sv
// Shared types and constants for the SPI-to-shift-register controller.
package spi_reg_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

  localparam int CMD_W  = 8;
  localparam int WR_BIT = 7;

endpackage

// File: rtl/spi_reg_controller_sync.sv
// Two-flop synchronizer for one SPI pin, with rise/fall detection on the
// synchronized value.
module spi_sync #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= IDLE_LVL;
      s2 <= IDLE_LVL;
      s3 <= IDLE_LVL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_reg_controller.sv
// SPI slave that addresses one of NREG serial shift registers per session:
// 8-bit command (write flag + address) followed by N data bits.
module spi_reg_controller
  import spi_reg_controller_pkg::*;
#(
  parameter int NREG = 4,
  parameter int N    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            spi_sck,
  input  logic            spi_cs_n,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            sr_reset_flag,
  output logic [NREG-1:0] sr_sel,
  output logic            sr_si,
  input  logic [NREG-1:0] sr_so,
  output logic [NREG-1:0] wr_strobe,
  output logic            cmd_err,
  output logic            abort
);

  localparam int CW = ($clog2(N + 1) > 4) ? $clog2(N + 1) : 4;

  logic sck_rise, sck_fall, unused_sck_q;
  logic cs_q, cs_rise, cs_fall;
  logic mosi_q, unused_mosi_rise, unused_mosi_fall;

  spi_sync #(.IDLE_LVL(1'b0)) u_sck (
    .clk(clk), .reset_n(reset_n), .din(spi_sck),
    .q(unused_sck_q), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync #(.IDLE_LVL(1'b1)) u_cs (
    .clk(clk), .reset_n(reset_n), .din(spi_cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync #(.IDLE_LVL(1'b0)) u_mosi (
    .clk(clk), .reset_n(reset_n), .din(spi_mosi),
    .q(mosi_q), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  state_t           state, state_n;
  logic [CMD_W-1:0] cmd_reg, cmd_n, cmd_shift;
  logic [CW-1:0]    bit_cnt, cnt_n;
  logic [NREG-1:0]  wr_n, sel_onehot;
  logic             miso_q, miso_n, so_sel;
  logic [1:0]       fill;
  logic             armed;

  // armed only sets once the cs_n pipeline holds real pin samples and reads
  // high, so a cs_n already low at reset release cannot start a session.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_reg   <= '0;
      bit_cnt   <= '0;
      wr_strobe <= '0;
      miso_q    <= 1'b0;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_reg   <= cmd_n;
      bit_cnt   <= cnt_n;
      wr_strobe <= wr_n;
      miso_q    <= miso_n;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && cs_q) armed <= 1'b1;
    end
  end

  always_comb begin
    sel_onehot = '0;
    so_sel     = 1'b0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (cmd_reg[CMD_W-2:0] == 7'(k)) begin
        sel_onehot[k] = 1'b1;
        so_sel        = sr_so[k];
      end
    end
  end

  always_comb begin
    state_n       = state;
    cmd_n         = cmd_reg;
    cnt_n         = bit_cnt;
    wr_n          = '0;
    miso_n        = 1'b0;
    sr_reset_flag = 1'b0;
    sr_sel        = '0;
    sr_si         = 1'b0;
    cmd_err       = 1'b0;
    abort         = 1'b0;
    cmd_shift     = {cmd_reg[CMD_W-2:0], mosi_q};
    unique case (state)
      IDLE: begin
        if (cs_fall && armed) begin
          state_n       = CMD;
          cnt_n         = '0;
          cmd_n         = '0;
          sr_reset_flag = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_n = IDLE;
        end else if (sck_rise) begin
          cmd_n = cmd_shift;
          if (bit_cnt == CW'(CMD_W - 1)) begin
            cnt_n = '0;
            if (int'(cmd_shift[CMD_W-2:0]) < NREG) begin
              state_n = DATA;
            end else begin
              state_n = DONE;
              cmd_err = 1'b1;
            end
          end else begin
            cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      DATA: begin
        miso_n = sck_fall ? so_sel : miso_q;
        if (cs_rise) begin
          state_n = IDLE;
          abort   = 1'b1;
        end else if (sck_rise) begin
          sr_sel = sel_onehot;
          sr_si  = mosi_q;
          if (bit_cnt == CW'(N - 1)) begin
            state_n = DONE;
            if (cmd_reg[WR_BIT]) wr_n = sel_onehot;
          end else begin
            cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      DONE: begin
        if (cs_rise) state_n = IDLE;
      end
    endcase
    if (!reset_n) begin
      sr_reset_flag = 1'b0;
      sr_sel        = '0;
      sr_si         = 1'b0;
      cmd_err       = 1'b0;
      abort         = 1'b0;
    end
  end

  assign spi_miso = reset_n & miso_q & (state == DATA);

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench: table of SPI sessions plus hand-written corner cases,
// with a queue-based scoreboard for shift enables and write strobes.
module tb_spi_reg_controller;

  localparam int NREG = 4;
  localparam int N    = 8;
  localparam int H    = 6;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            spi_sck, spi_cs_n, spi_mosi, spi_miso;
  logic            sr_reset_flag, sr_si, cmd_err, abort;
  logic [NREG-1:0] sr_sel, sr_so, wr_strobe;

  spi_reg_controller #(.NREG(NREG), .N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .sr_reset_flag(sr_reset_flag), .sr_sel(sr_sel), .sr_si(sr_si), .sr_so(sr_so),
    .wr_strobe(wr_strobe), .cmd_err(cmd_err), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] addr;
    logic       b;
  } sel_t;

  typedef struct {
    logic [7:0]  cmd;
    int          ncmd;
    logic [15:0] data;
    int          nbits;
    logic [15:0] exp_rd;
    int          exp_err;
    int          exp_abort;
  } vec_t;

  sel_t       exp_sel_q[$];
  logic [3:0] exp_wr_q[$];
  logic [7:0] preload [NREG];
  logic [7:0] sr_model[NREG];
  logic [3:0] prev_sel;
  vec_t       vecs[10];

  int checks = 0;
  int errors = 0;
  int rflag_seen, err_seen, abort_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of monitoring: sample at negedge, score outputs, emulate registers.
  task automatic tick();
    sel_t e;
    @(negedge clk);
    if (!reset_n) begin
      check("reset_outputs",
            {spi_miso, sr_reset_flag, sr_sel, sr_si, wr_strobe, cmd_err, abort}, '0);
      prev_sel = '0;
    end else begin
      if (sr_reset_flag) begin
        rflag_seen++;
        for (int k = 0; k < NREG; k++) sr_model[k] = preload[k];
      end
      if (cmd_err) err_seen++;
      if (abort) abort_seen++;
      if (sr_sel != '0) begin
        if (exp_sel_q.size() == 0) begin
          check("unexpected_sel", sr_sel, 0);
        end else begin
          e = exp_sel_q.pop_front();
          check("sel_addr", sr_sel, 4'b0001 << e.addr);
          check("sel_si", sr_si, e.b);
        end
        for (int k = 0; k < NREG; k++)
          if (sr_sel[k]) sr_model[k] = {sr_model[k][6:0], sr_si};
      end
      if (wr_strobe != '0) begin
        check("wr_gap", {sr_sel, prev_sel}, {4'b0000, wr_strobe});
        if (exp_wr_q.size() == 0) check("unexpected_wr", wr_strobe, 0);
        else check("wr_strobe", wr_strobe, exp_wr_q.pop_front());
      end
      prev_sel = sr_sel;
    end
    for (int k = 0; k < NREG; k++) sr_so[k] = sr_model[k][7];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [15:0] val, input int n, output logic [15:0] rd);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = val[n-1-i];
      wait_cyc(H);
      r = {r[14:0], spi_miso};
      spi_sck = 1'b1;
      wait_cyc(H);
      spi_sck = 1'b0;
    end
    rd = r;
  endtask

  task automatic session(input logic [7:0] cmd, input int ncmd, input logic [15:0] data,
                         input int nbits, input int gap, output logic [15:0] rd);
    logic [15:0] dummy;
    bit valid;
    int nsel;
    valid = (ncmd == 8) && (cmd[6:0] < 7'd4);
    nsel  = (nbits > 8) ? 8 : nbits;
    if (valid)
      for (int i = 0; i < nsel; i++) exp_sel_q.push_back('{addr: cmd[6:0], b: data[nbits-1-i]});
    if (valid && cmd[7] && nbits >= 8) exp_wr_q.push_back(4'(4'b0001 << cmd[6:0]));
    spi_cs_n = 1'b0;
    wait_cyc(H);
    send_bits({8'h00, cmd} >> (8 - ncmd), ncmd, dummy);
    rd = '0;
    if (ncmd == 8) send_bits(data, nbits, rd);
    wait_cyc(H);
    spi_cs_n = 1'b1;
    wait_cyc(gap);
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_sel_missing"}, exp_sel_q.size(), 0);
    check({tag, "_wr_missing"}, exp_wr_q.size(), 0);
    exp_sel_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    logic [15:0] rd, dummy;
    //          cmd    ncmd data     nbits exp_rd    err abort
    vecs[0] = '{8'h82, 8, 16'h00A5, 8,  16'h005A, 0, 0};
    vecs[1] = '{8'h01, 8, 16'h0000, 8,  16'h003C, 0, 0};
    vecs[2] = '{8'h87, 8, 16'h00FF, 8,  16'h0000, 1, 0};
    vecs[3] = '{8'h80, 8, 16'h0007, 3,  16'h0004, 0, 1};
    vecs[4] = '{8'h83, 8, 16'h003F, 10, 16'h030C, 0, 0};
    vecs[5] = '{8'h84, 8, 16'h00AA, 8,  16'h0000, 1, 0};
    vecs[6] = '{8'h00, 8, 16'h0055, 8,  16'h0096, 0, 0};
    vecs[7] = '{8'h81, 8, 16'h0000, 0,  16'h0000, 0, 1};
    vecs[8] = '{8'h82, 8, 16'h0055, 7,  16'h002D, 0, 1};
    vecs[9] = '{8'h82, 4, 16'h0000, 0,  16'h0000, 0, 0};
    preload[0] = 8'h96;
    preload[1] = 8'h3C;
    preload[2] = 8'h5A;
    preload[3] = 8'hC3;
    for (int k = 0; k < NREG; k++) sr_model[k] = preload[k];
    prev_sel = '0;
    sr_so = '0;
    rflag_seen = 0; err_seen = 0; abort_seen = 0;

    // Reset with cs_n already low: must not start a session afterwards.
    reset_n = 1'b0;
    spi_cs_n = 1'b0;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    wait_cyc(4);
    reset_n = 1'b1;
    wait_cyc(12);
    send_bits(16'h00FF, 3, dummy);
    spi_cs_n = 1'b1;
    wait_cyc(10);
    send_bits(16'h00FF, 3, dummy);
    wait_cyc(4);
    check("stale_cs_rflag", rflag_seen, 0);
    check("stale_cs_err", err_seen + abort_seen, 0);

    for (int i = 0; i < 10; i++) begin
      rflag_seen = 0; err_seen = 0; abort_seen = 0;
      session(vecs[i].cmd, vecs[i].ncmd, vecs[i].data, vecs[i].nbits, 8, rd);
      check($sformatf("v%0d_miso", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_cmd_err", i), err_seen, vecs[i].exp_err);
      check($sformatf("v%0d_abort", i), abort_seen, vecs[i].exp_abort);
      check($sformatf("v%0d_rflag", i), rflag_seen, 1);
      drain_check($sformatf("v%0d", i));
    end

    // cs_n rise and sck rise in the same cycle: cs_n wins, no third enable.
    rflag_seen = 0; err_seen = 0; abort_seen = 0;
    exp_sel_q.push_back('{addr: 7'd0, b: 1'b1});
    exp_sel_q.push_back('{addr: 7'd0, b: 1'b0});
    spi_cs_n = 1'b0;
    wait_cyc(H);
    send_bits(16'h0080, 8, dummy);
    send_bits(16'h0002, 2, dummy);
    spi_mosi = 1'b1;
    wait_cyc(H);
    spi_sck = 1'b1;
    spi_cs_n = 1'b1;
    wait_cyc(H);
    spi_sck = 1'b0;
    wait_cyc(8);
    check("tie_abort", abort_seen, 1);
    drain_check("tie");

    // Reset after 5 data bits, then a full write session to register 1.
    rflag_seen = 0; err_seen = 0; abort_seen = 0;
    for (int i = 0; i < 5; i++) exp_sel_q.push_back('{addr: 7'd1, b: 1'b1});
    spi_cs_n = 1'b0;
    wait_cyc(H);
    send_bits(16'h0081, 8, dummy);
    send_bits(16'h001F, 5, dummy);
    wait_cyc(2);
    reset_n = 1'b0;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(6);
    spi_cs_n = 1'b1;
    wait_cyc(8);
    check("midreset_err_abort", err_seen + abort_seen, 0);
    drain_check("midreset");
    session(8'h81, 8, 16'h00FF, 8, 8, rd);
    check("post_reset_rflag", rflag_seen, 2);
    drain_check("post_reset");

    // Back-to-back sessions with cs_n high for 4 clocks in between.
    rflag_seen = 0; err_seen = 0; abort_seen = 0;
    session(8'h80, 8, 16'h0011, 8, 4, rd);
    session(8'h83, 8, 16'h0022, 8, 8, rd);
    check("b2b_rflag", rflag_seen, 2);
    check("b2b_err_abort", err_seen + abort_seen, 0);
    drain_check("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_controller.md
SPI_REG_CONTROLLER -- requirements
Module: spi_reg_controller

Interface
REQ-001 Parameter NREG, default 4, is the number of attached shift registers (1..128).
REQ-002 Parameter N, default 8, is the data width of each attached shift register, in bits (N >= 2).
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 spi_sck, spi_cs_n, spi_mosi  in  1 each  asynchronous SPI slave pins, mode 0, MSB first.
REQ-006 spi_miso  out  1  serial read data.
REQ-007 sr_reset_flag  out  1  one-cycle pulse that reloads all attached shift registers at session start.
REQ-008 sr_sel  out  NREG  one-hot shift enables, one bit per register.
REQ-009 sr_si  out  1  shared serial input to all registers.
REQ-010 sr_so  in  NREG  serial outputs of the registers.
REQ-011 wr_strobe  out  NREG  one-cycle pulse: register k has completed a write session.
REQ-012 cmd_err  out  1  one-cycle pulse: the session addressed a register index >= NREG.
REQ-013 abort  out  1  one-cycle pulse: spi_cs_n rose before all N data bits arrived.

Function
REQ-014 spi_sck, spi_cs_n and spi_mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized value, so each edge is seen 3 clk after the pin change.
REQ-015 The state machine SHALL have the states IDLE, CMD, DATA and DONE.
REQ-016 IDLE->CMD on a synced cs_n fall; in that cycle sr_reset_flag = 1 and the bit counter is cleared.
REQ-017 In CMD, each synced sck rise SHALL shift sync mosi into an 8-bit command register; bit7 = write flag, bits[6:0] = address.
REQ-018 On the 8th CMD sck rise, the next state is DATA if address < NREG; otherwise it is DONE, with cmd_err pulsed for 1 cycle.
REQ-019 In DATA, each synced sck rise SHALL assert sr_sel[address] for exactly 1 clk, with sr_si = sync mosi in the same cycle; all other sr_sel bits stay 0.
REQ-020 After the Nth DATA sck rise, the state SHALL go to DONE; if the write flag is set, wr_strobe[address] pulses 1 cycle later, never in the same cycle as the last sr_sel.
REQ-021 In DONE, further sck edges SHALL be ignored; a synced cs_n rise goes to IDLE.
REQ-022 A synced cs_n rise in CMD or DATA SHALL go to IDLE immediately.
REQ-023 A cs_n rise in DATA SHALL pulse abort and produce no wr_strobe; a cs_n rise in CMD SHALL be silent.
REQ-024 A cs_n rise and an sck rise in the same cycle: the cs_n rise wins, and no sr_sel is issued.
REQ-025 spi_miso SHALL update on each synced sck fall in DATA to sr_so[address]; in all other states it is 0.
REQ-026 Bit counter width SHALL be max($clog2(N+1),4); it never wraps within a session.
REQ-027 In IDLE, sck edges SHALL be ignored.

Reset
REQ-028 While reset_n = 0 at posedge clk: state = IDLE, counters = 0, command register = 0, all synchronizer flops = idle level (cs_n = 1, sck = 0, mosi = 0), and all outputs = 0.
REQ-029 A reset asserted mid-session SHALL issue no wr_strobe, abort or cmd_err.
REQ-030 After reset is released, a session begins only on a fresh synced cs_n fall; a cs_n that is already low SHALL be ignored until it has gone high.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, CMD, DATA, DONE), CMD_W = 8, and the write-flag bit index 7.
REQ-032 The 2-flop synchronizer with edge detect SHALL be the sub-module spi_sync, instantiated 3 times.

Verification
REQ-033 NREG=4, N=8: command 0x82, data 0xA5 -> sr_sel[2] pulses 8 times, sr_si sequence 1,0,1,0,0,1,0,1, and wr_strobe = 4'b0100 pulses once.
REQ-034 Command 0x01 (read, reg 1) with sr_so[1] driving 0x3C -> spi_miso carries 0x3C MSB-first, and wr_strobe stays 0.
REQ-035 Command 0x87 with NREG=4 -> cmd_err pulses once, sr_sel stays 0 for the rest of the session, and spi_miso = 0.
REQ-036 Command 0x80, 3 data bits, then cs_n high -> abort pulses once, with 3 sr_sel[0] pulses and no wr_strobe.
REQ-037 reset_n low after data bit 5, then released, then a full 0x81/0xFF session -> no outputs during reset, and wr_strobe[1] pulses after the second session.
REQ-038 Two back-to-back sessions with cs_n high for 4 clk between them -> sr_reset_flag pulses once per session, and both wr_strobes occur.
